mfp_ahb_gpio_irq: RTL and testbench
===================================

// Module: mfp_ahb_gpio_irq
// PURPOSE
//  AHB-Lite slave with PORT_COUNT GPIO ports of PORT_WIDTH bits each. Every port has:
//  per-bit direction, atomic set/clear of outputs, and edge-triggered interrupts with sticky status.
//  Sits on the mfp AHB-Lite decoder beside the RAM/ROM slaves. Drives board pins and one irq line per port to the CPU.
// PARAMETERS
//  PORT_COUNT   1   number of GPIO ports (1..16)
//  PORT_WIDTH   32  bits per port (1..32); unused HRDATA bits read 0
//  HDATA_WIDTH  32  AHB data width (fixed 32)
// PORTS
//  HCLK       in   1                       bus clock; the only clock
//  HRESETn    in   1                       asynchronous active-low reset
//  HADDR      in   32                      address; [4:2]=register, [8:5]=port index
//  HTRANS     in   2                       NONSEQ/SEQ start a transfer
//  HSIZE      in   3                       only 3'b010 (word) writes take effect
//  HWRITE     in   1                       1=write
//  HSEL       in   1                       slave select
//  HREADY     in   1                       bus ready (address phase qualifier)
//  HWDATA     in   32                      write data (data phase)
//  HRDATA     out  32                      read data (data phase)
//  HREADYOUT  out  1                       constant 1 (zero wait states)
//  HRESP      out  1                       constant 0 (OKAY)
//  gpio_in    in   [PORT_COUNT][PORT_WIDTH] pin inputs
//  gpio_out   out  [PORT_COUNT][PORT_WIDTH] pin output values
//  gpio_oe    out  [PORT_COUNT][PORT_WIDTH] output enables (1=drive)
//  irq        out  PORT_COUNT              per-port |(IRQ_STAT & IRQ_EN), registered
// BEHAVIOUR
//  Address phase is captured when HSEL&HREADY&HTRANS[1]: addr, write, size are registered. The data phase acts on HWDATA next cycle.
//  Reads: HRDATA is driven combinationally from the captured addr in the data phase. Back-to-back transfers are supported.
//  Register map per port (offset 0x00..0x1C):
//   0 DATA_IN RO; 1 DATA_OUT RW; 2 OUT_SET WO (OUT|=wd); 3 OUT_CLR WO (OUT&=~wd);
//   4 DIR RW (1=out, drives gpio_oe); 5 IRQ_EN RW; 6 IRQ_EDGE RW (1=rising, 0=falling);
//   7 IRQ_STAT R/W1C. WO registers read 0.
//  Port index >= PORT_COUNT: reads 0, writes dropped. Non-word writes are dropped, HRESP stays OKAY.
//  Reset: DATA_OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STAT, edge history, irq, HRDATA = 0.
//  Edge detect: prev <= in every cycle. ev = IRQ_EDGE ? in&~prev : ~in&prev.
//  IRQ_STAT |= ev&IRQ_EN. If a W1C and an edge hit the same bit in the same cycle, the set wins.
//  IRQ_EN cleared: the STAT bit is kept, but it is masked from irq.
//  irq updates 1 cycle after STAT. A DATA_OUT write is visible on gpio_out the cycle after the data phase.
//  Reset mid-transfer: the pending data phase is discarded; HREADYOUT is still 1.
// CONFIGURATION
//  MFP_AHB_GPIO_IRQ_SYNC_EN defined:
//   gpio_in passes a 2-flop synchroniser (reset 0) before DATA_IN and edge logic.
//   A pin change is visible in DATA_IN 2 cycles later and in IRQ_STAT 3 cycles later.
//  Not defined:
//   gpio_in is used directly and must be HCLK-synchronous.
//   DATA_IN follows the pin combinationally; IRQ_STAT is set at the first clock edge that sees the change.
// STRUCTURE
//  Package mfp_ahb_gpio_irq_pkg holds:
//   register offset localparams (REG_DATA_IN..REG_IRQ_STAT)
//   HTRANS_NONSEQ/SEQ constants
//   HSIZE_WORD
//   the typedef of the per-port register struct
//  Sub-module mfp_gpio_irq_port (one port: registers, optional sync, edge detect, irq) is instantiated PORT_COUNT times by generate.
//  The top holds AHB phase capture, write decode and the read mux.
// TESTING
//  1 Reset, then read all regs of port 0 -> all 0; HREADYOUT=1, HRESP=0 throughout.
//  2 Write DIR=0xFFFF0000, DATA_OUT=0x12345678, OUT_SET=0x0F, OUT_CLR=0x10000000
//    -> gpio_oe=0xFFFF0000, gpio_out=0x0234567F; DATA_OUT reads back 0x0234567F.
//  3 IRQ_EN=0x1, IRQ_EDGE=0x1, drive gpio_in[0] 0->1 -> IRQ_STAT=0x1, irq[0]=1.
//    Write IRQ_STAT=0x1 -> both 0. Repeat with falling edge and IRQ_EDGE=0.
//  4 With IRQ_EDGE=1, a W1C to bit 0 in the same cycle as a new rising edge -> IRQ_STAT[0] stays 1.
//  5 PORT_COUNT=2: write port 1 DATA_OUT=0xA5 (addr 0x24) -> port 0 unchanged.
//    Access to port index 3 -> reads 0, no state change. Byte write to DATA_OUT -> ignored.
//  6 Back-to-back write DATA_OUT then read DATA_OUT -> the read returns the new value.
//    Run both with and without MFP_AHB_GPIO_IRQ_SYNC_EN, checking latencies of 3 and 1 cycles.

Source files
------------

// File: rtl/mfp_ahb_gpio_irq_pkg.sv
// Shared constants and register struct for the AHB-Lite GPIO block with per-port edge interrupts.
// Optional input synchroniser selected by MFP_AHB_GPIO_IRQ_SYNC_EN (see mfp_gpio_irq_port).
package mfp_ahb_gpio_irq_pkg;

  localparam logic [2:0] REG_DATA_IN  = 3'd0;
  localparam logic [2:0] REG_DATA_OUT = 3'd1;
  localparam logic [2:0] REG_OUT_SET  = 3'd2;
  localparam logic [2:0] REG_OUT_CLR  = 3'd3;
  localparam logic [2:0] REG_DIR      = 3'd4;
  localparam logic [2:0] REG_IRQ_EN   = 3'd5;
  localparam logic [2:0] REG_IRQ_EDGE = 3'd6;
  localparam logic [2:0] REG_IRQ_STAT = 3'd7;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef struct packed {
    logic [31:0] data_out;
    logic [31:0] dir;
    logic [31:0] irq_en;
    logic [31:0] irq_edge;
    logic [31:0] irq_stat;
  } gpio_regs_t;

  // Keeps bits above PORT_WIDTH permanently zero so they read back as 0.
  function automatic logic [31:0] width_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/mfp_gpio_irq_port.sv
// One GPIO port: output/direction/irq registers, edge detector with sticky status, registered irq.
// MFP_AHB_GPIO_IRQ_SYNC_EN inserts a 2-flop synchroniser on the pins ahead of DATA_IN and edge logic.
module mfp_gpio_irq_port
  import mfp_ahb_gpio_irq_pkg::*;
#(
  parameter int PORT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [2:0]            wr_reg_i,
  input  logic [31:0]           wr_dat_i,
  input  logic [PORT_WIDTH-1:0] pin_i,
  output gpio_regs_t            regs_o,
  output logic [31:0]           din_o,
  output logic [PORT_WIDTH-1:0] out_o,
  output logic [PORT_WIDTH-1:0] oe_o,
  output logic                  irq_o
);

  localparam logic [31:0] MASK = width_mask(PORT_WIDTH);

  gpio_regs_t  regs_q, regs_d;
  logic [31:0] in_w, prev_q, ev_w, wd_w, w1c_w;
  logic        irq_q;

`ifdef MFP_AHB_GPIO_IRQ_SYNC_EN
  logic [31:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= 32'(pin_i);
      sync2_q <= sync1_q;
    end
  end

  assign in_w = sync2_q;
`else
  assign in_w = 32'(pin_i);
`endif

  assign ev_w = (regs_q.irq_edge & in_w & ~prev_q) | (~regs_q.irq_edge & ~in_w & prev_q);
  assign wd_w = wr_dat_i & MASK;

  always_comb begin
    regs_d = regs_q;
    w1c_w  = '0;
    if (wr_en_i) begin
      case (wr_reg_i)
        REG_DATA_OUT: regs_d.data_out = wd_w;
        REG_OUT_SET:  regs_d.data_out = regs_q.data_out | wd_w;
        REG_OUT_CLR:  regs_d.data_out = regs_q.data_out & ~wd_w;
        REG_DIR:      regs_d.dir      = wd_w;
        REG_IRQ_EN:   regs_d.irq_en   = wd_w;
        REG_IRQ_EDGE: regs_d.irq_edge = wd_w;
        REG_IRQ_STAT: w1c_w           = wd_w;
        default:      ;
      endcase
    end
    // A new event outranks a simultaneous write-one-to-clear on the same bit.
    regs_d.irq_stat = (regs_q.irq_stat & ~w1c_w) | (ev_w & regs_q.irq_en);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      regs_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      prev_q <= in_w;
      irq_q  <= |(regs_q.irq_stat & regs_q.irq_en);
    end
  end

  assign regs_o = regs_q;
  assign din_o  = in_w;
  assign out_o  = regs_q.data_out[PORT_WIDTH-1:0];
  assign oe_o   = regs_q.dir[PORT_WIDTH-1:0];
  assign irq_o  = irq_q;

endmodule

// File: rtl/mfp_ahb_gpio_irq.sv
// AHB-Lite GPIO slave: address-phase capture, write decode to PORT_COUNT ports, combinational read mux.
// Zero wait states, always OKAY; input synchroniser optional via MFP_AHB_GPIO_IRQ_SYNC_EN.
module mfp_ahb_gpio_irq
  import mfp_ahb_gpio_irq_pkg::*;
#(
  parameter int PORT_COUNT  = 1,
  parameter int PORT_WIDTH  = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  logic                                  HCLK,
  input  logic                                  HRESETn,
  input  logic [31:0]                           HADDR,
  input  logic [1:0]                            HTRANS,
  input  logic [2:0]                            HSIZE,
  input  logic                                  HWRITE,
  input  logic                                  HSEL,
  input  logic                                  HREADY,
  input  logic [HDATA_WIDTH-1:0]                HWDATA,
  output logic [HDATA_WIDTH-1:0]                HRDATA,
  output logic                                  HREADYOUT,
  output logic                                  HRESP,
  input  logic [PORT_COUNT-1:0][PORT_WIDTH-1:0] gpio_in,
  output logic [PORT_COUNT-1:0][PORT_WIDTH-1:0] gpio_out,
  output logic [PORT_COUNT-1:0][PORT_WIDTH-1:0] gpio_oe,
  output logic [PORT_COUNT-1:0]                 irq
);

  logic       vld_q, vld_d, wr_q, port_hit, wr_ok;
  logic [2:0] size_q, reg_q;
  logic [3:0] port_q;
  logic [31:0] rd_dat;
  logic        unused_addr;

  gpio_regs_t  port_regs [PORT_COUNT];
  logic [31:0] port_din  [PORT_COUNT];

  assign vld_d = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign unused_addr = ^{HADDR[31:9], HADDR[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_q  <= 1'b0;
      wr_q   <= 1'b0;
      size_q <= '0;
      reg_q  <= '0;
      port_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (vld_d) begin
        wr_q   <= HWRITE;
        size_q <= HSIZE;
        reg_q  <= HADDR[4:2];
        port_q <= HADDR[8:5];
      end
    end
  end

  assign port_hit = ({1'b0, port_q} < 5'(PORT_COUNT));
  assign wr_ok    = vld_q & wr_q & (size_q == HSIZE_WORD) & port_hit;

  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
    mfp_gpio_irq_port #(.PORT_WIDTH(PORT_WIDTH)) u_port (
      .clk_i    (HCLK),
      .rst_n_i  (HRESETn),
      .wr_en_i  (wr_ok && (port_q == 4'(g))),
      .wr_reg_i (reg_q),
      .wr_dat_i (HWDATA),
      .pin_i    (gpio_in[g]),
      .regs_o   (port_regs[g]),
      .din_o    (port_din[g]),
      .out_o    (gpio_out[g]),
      .oe_o     (gpio_oe[g]),
      .irq_o    (irq[g])
    );
  end

  // Unmatched port indices fall through the loop and read as zero.
  always_comb begin
    rd_dat = '0;
    if (vld_q && !wr_q) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (port_q == 4'(p)) begin
          case (reg_q)
            REG_DATA_IN:  rd_dat = port_din[p];
            REG_DATA_OUT: rd_dat = port_regs[p].data_out;
            REG_DIR:      rd_dat = port_regs[p].dir;
            REG_IRQ_EN:   rd_dat = port_regs[p].irq_en;
            REG_IRQ_EDGE: rd_dat = port_regs[p].irq_edge;
            REG_IRQ_STAT: rd_dat = port_regs[p].irq_stat;
            default:      rd_dat = '0;
          endcase
        end
      end
    end
  end

  assign HRDATA    = rd_dat;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_mfp_ahb_gpio_irq.sv
// Directed and randomized bench for mfp_ahb_gpio_irq with two 32-bit ports.
module tb_mfp_ahb_gpio_irq;

  localparam int PC = 2;
`ifdef MFP_AHB_GPIO_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [2:0] WORD = 3'b010;

  logic              HCLK, HRESETn, HWRITE, HSEL, HREADY, HREADYOUT, HRESP;
  logic [31:0]       HADDR, HWDATA, HRDATA;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [PC-1:0][31:0] gpio_in, gpio_out, gpio_oe;
  logic [PC-1:0]     irq;

  int n_checks = 0;
  int n_fail   = 0;

  mfp_ahb_gpio_irq #(.PORT_COUNT(PC), .PORT_WIDTH(32), .HDATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HSEL(HSEL), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] ra(input int p, input int r);
    return 32'((p << 5) | (r << 2));
  endfunction

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz = WORD);
    addr_ph(a, 1'b1, sz);
    tick();
    idle();
    HWDATA = d;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_ph(a, 1'b0, WORD);
    tick();
    idle();
    d = HRDATA;
    chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("hresp", {31'd0, HRESP}, 32'd0);
  endtask

  logic [31:0] rdv, exp_v, nw, ev;
  logic [31:0] m_out [PC], m_dir [PC], m_en [PC], m_edge [PC], m_stat [PC], m_pin [PC];

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HWDATA = '0; HADDR = '0; HSIZE = WORD;
    idle();
    gpio_in = '0;
    repeat (2) tick();
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_out0", gpio_out[0], 32'd0);
    chk("rst_oe0", gpio_oe[0], 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    HRESETn = 1'b1;
    tick();

    // Reset values of every port-0 register
    for (int r = 0; r < 8; r++) begin
      rd(ra(0, r), rdv);
      chk($sformatf("rst_reg%0d", r), rdv, 32'd0);
    end

    // Output, set/clear and direction
    wr(ra(0, 4), 32'hFFFF_0000);
    chk("dir_oe", gpio_oe[0], 32'hFFFF_0000);
    wr(ra(0, 1), 32'h1234_5678);
    wr(ra(0, 2), 32'h0000_000F);
    wr(ra(0, 3), 32'h1000_0000);
    chk("out_setclr", gpio_out[0], 32'h0234_567F);
    rd(ra(0, 1), rdv);
    chk("out_readback", rdv, 32'h0234_567F);
    rd(ra(0, 2), rdv);
    chk("set_reads0", rdv, 32'd0);

    // Rising-edge interrupt and its latencies
    wr(ra(0, 5), 32'h1);
    wr(ra(0, 6), 32'h1);
    gpio_in[0] = 32'h1;
    rd(ra(0, 0), rdv);
    chk("din_latency", rdv, (LAT == 1) ? 32'h1 : 32'h0);
    repeat (LAT - 1) tick();
    chk("irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    rd(ra(0, 0), rdv);
    chk("din_settled", rdv, 32'h1);
    rd(ra(0, 7), rdv);
    chk("stat_rise", rdv, 32'h1);
    wr(ra(0, 7), 32'h1);
    rd(ra(0, 7), rdv);
    chk("stat_w1c", rdv, 32'h0);
    chk("irq_w1c", 32'(irq), 32'd0);

    // Falling-edge interrupt
    wr(ra(0, 6), 32'h0);
    gpio_in[0] = 32'h0;
    repeat (LAT + 1) tick();
    chk("irq_fall", 32'(irq), 32'd1);
    rd(ra(0, 7), rdv);
    chk("stat_fall", rdv, 32'h1);
    wr(ra(0, 7), 32'h1);
    rd(ra(0, 7), rdv);
    chk("stat_fall_w1c", rdv, 32'h0);

    // W1C landing on the same edge as a new rising event: the event wins
    wr(ra(0, 6), 32'h1);
    gpio_in[0] = 32'h1;
    repeat (LAT + 1) tick();
    gpio_in[0] = 32'h0;
    repeat (LAT + 1) tick();
    if (LAT >= 2) begin
      gpio_in[0] = 32'h1;
      repeat (LAT - 2) tick();
      addr_ph(ra(0, 7), 1'b1, WORD);
      tick();
      idle();
      HWDATA = 32'h1;
      tick();
    end else begin
      addr_ph(ra(0, 7), 1'b1, WORD);
      tick();
      idle();
      HWDATA = 32'h1;
      gpio_in[0] = 32'h1;
      tick();
    end
    rd(ra(0, 7), rdv);
    chk("set_beats_w1c", rdv, 32'h1);
    wr(ra(0, 7), 32'h1);
    rd(ra(0, 7), rdv);
    chk("stat_cleared", rdv, 32'h0);

    // Port select, out-of-range port, byte write
    wr(32'h24, 32'h0000_00A5);
    chk("port1_out", gpio_out[1], 32'h0000_00A5);
    chk("port0_kept", gpio_out[0], 32'h0234_567F);
    wr(ra(3, 1), 32'hFFFF_FFFF);
    rd(ra(3, 1), rdv);
    chk("port3_reads0", rdv, 32'd0);
    chk("port3_p0", gpio_out[0], 32'h0234_567F);
    chk("port3_p1", gpio_out[1], 32'h0000_00A5);
    wr(ra(0, 1), 32'hDEAD_BEEF, 3'b000);
    chk("byte_ignored", gpio_out[0], 32'h0234_567F);

    // Back-to-back write then read of DATA_OUT
    addr_ph(ra(0, 1), 1'b1, WORD);
    tick();
    HWDATA = 32'hCAFE_F00D;
    addr_ph(ra(0, 1), 1'b0, WORD);
    tick();
    idle();
    chk("b2b_read", HRDATA, 32'hCAFE_F00D);
    chk("b2b_out", gpio_out[0], 32'hCAFE_F00D);

    // Reset asserted during a write data phase discards the write
    gpio_in = '0;
    addr_ph(ra(0, 1), 1'b1, WORD);
    tick();
    idle();
    HWDATA = 32'h5555_AAAA;
    HRESETn = 1'b0;
    #2;
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    tick();
    HRESETn = 1'b1;
    tick();
    chk("rst_mid_out", gpio_out[0], 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);

    // Randomized operations against a register-level model
    for (int p = 0; p < PC; p++) begin
      m_out[p] = '0; m_dir[p] = '0; m_en[p] = '0; m_edge[p] = '0; m_stat[p] = '0; m_pin[p] = '0;
    end
    for (int it = 0; it < 150; it++) begin
      int op, p, r;
      op = $urandom_range(0, 2);
      p  = $urandom_range(0, PC - 1);
      r  = $urandom_range(0, 7);
      if (op == 0) begin
        nw = $urandom;
        wr(ra(p, r), nw);
        case (r)
          1: m_out[p] = nw;
          2: m_out[p] = m_out[p] | nw;
          3: m_out[p] = m_out[p] & ~nw;
          4: m_dir[p] = nw;
          5: m_en[p] = nw;
          6: m_edge[p] = nw;
          7: m_stat[p] = m_stat[p] & ~nw;
          default: ;
        endcase
        chk("rnd_out", gpio_out[p], m_out[p]);
        chk("rnd_oe", gpio_oe[p], m_dir[p]);
      end else if (op == 1) begin
        int q;
        q = $urandom_range(0, 3);
        rd(ra(q, r), rdv);
        exp_v = '0;
        if (q < PC) begin
          case (r)
            0: exp_v = m_pin[q];
            1: exp_v = m_out[q];
            4: exp_v = m_dir[q];
            5: exp_v = m_en[q];
            6: exp_v = m_edge[q];
            7: exp_v = m_stat[q];
            default: exp_v = '0;
          endcase
        end
        chk($sformatf("rnd_rd_p%0d_r%0d", q, r), rdv, exp_v);
      end else begin
        nw = $urandom;
        if ($urandom_range(0, 1) == 1) nw = nw & $urandom;
        gpio_in[p] = nw;
        repeat (LAT + 2) tick();
        for (int b = 0; b < 32; b++) begin
          if (m_edge[p][b]) ev[b] = nw[b] && !m_pin[p][b];
          else              ev[b] = !nw[b] && m_pin[p][b];
        end
        m_stat[p] = m_stat[p] | (ev & m_en[p]);
        m_pin[p]  = nw;
        chk("rnd_irq", {31'd0, irq[p]}, {31'd0, (m_stat[p] & m_en[p]) != 0});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
